alu_issue_sequencer: RTL and testbench
======================================

// Module: alu_issue_sequencer
// PURPOSE
//  Front-end controller for the ALU top (instruction reg file + ALU). Accepts one
//  {opcode,A,B} request per valid/ready handshake and performs the three reg-file
//  writes (addr 0=opcode, 1=A, 2=B). It waits for the ALU to settle, with extra
//  cycles for MULT, then returns result+flags on a valid/ready response channel.
//  Replaces bench-style manual loading, so a master no longer pulses writes directly.
// PARAMETERS
//  OPERAND_WIDTH      8      width of opcode/operand/result bus
//  INST_ADDR_LENGTH   2      reg-file write address width
//  OP_MULT_CODE       8'h05  opcode value that triggers the MULT extra wait
//  SETTLE_CYCLES      1      WAIT cycles after last write (>=1)
//  MULT_EXTRA_CYCLES  1      additional WAIT cycles when opcode==OP_MULT_CODE
//  CNT_WIDTH          16     width of the statistics counters
// PORTS
//  clk             in   1                 clock, all logic on rising edge
//  rst             in   1                 synchronous reset, active-high
//  reqValid        in   1                 request present
//  reqReady        out  1                 sequencer can accept (state IDLE)
//  reqOp           in   OPERAND_WIDTH     opcode
//  reqA            in   OPERAND_WIDTH     operand A
//  reqB            in   OPERAND_WIDTH     operand B
//  rspValid        out  1                 response held valid
//  rspReady        in   1                 consumer takes response
//  rspResult       out  OPERAND_WIDTH     captured ALU result
//  rspFlags        out  4                 captured {error,zero,carry,overflow}
//  aluWriteEn      out  1                 to ALU top writeEn
//  aluWriteAddress out  INST_ADDR_LENGTH  to ALU top writeAddress
//  aluInst         out  OPERAND_WIDTH     to ALU top inst
//  aluResult       in   OPERAND_WIDTH     from ALU top result
//  aluFlags        in   4                 from ALU {error,zero,carry,overflow}
//  busy            out  1                 state != IDLE
//  txnCount        out  CNT_WIDTH         completed responses, wraps at 2^CNT_WIDTH
//  errCount        out  CNT_WIDTH         responses with error flag, saturates at all-ones
// BEHAVIOUR
//  Reset: state=IDLE, reqReady=1, rspValid=0, rspResult=0, rspFlags=0,
//   aluWriteEn=0, aluWriteAddress=0, aluInst=0, busy=0, txnCount=0, errCount=0.
//  FSM: IDLE -> WR_OP -> WR_A -> WR_B -> WAIT -> RESP -> IDLE.
//  - IDLE: reqReady=1. On reqValid&reqReady latch op/A/B and go to WR_OP.
//  - WR_OP/WR_A/WR_B: one cycle each, aluWriteEn=1, address 0/1/2, aluInst=op/A/B.
//  - WAIT: aluWriteEn=0, aluInst=0. Counter loads N=SETTLE_CYCLES, plus
//    MULT_EXTRA_CYCLES if op==OP_MULT_CODE. It decrements each cycle. On the
//    edge where the counter==1, capture aluResult/aluFlags and go to RESP.
//  - RESP: rspValid=1 and outputs stable until rspReady. On handshake go to IDLE,
//    increment txnCount and increment errCount when rspFlags[3]==1.
//  Latency: accept edge E0; writes occur in the 3 cycles after E0; rspValid rises
//   after edge E(3+N). Defaults: 4 cycles for non-MULT, 5 cycles for MULT.
//  Throughput: no bypass, and reqReady=0 in every state except IDLE. Minimum
//   spacing between accepts is 5+N cycles when rspReady is held high.
//  Opcode is not decoded beyond the MULT compare. Invalid opcodes, bad rotate
//   amounts and divide-by-zero pass through, and are reported via the captured error flag.
//  reqValid in non-IDLE states is ignored and request inputs are not sampled.
//  rspReady while rspValid=0 has no effect.
//  rst mid-operation: next cycle is IDLE, any partially written reg-file entries
//   are left as-is, and the pending response is discarded (rspValid=0).
//  rst has priority over every handshake in the same cycle.
//  rspResult/rspFlags change only at the capture edge or at reset.
// TESTING
//  ADD 8'h30+8'h25, rspReady=1 -> writes addr0/1/2 in 3 consecutive cycles;
//   rspValid 4 cycles after accept; result 8'h55, flags 4'b0000; txnCount=1.
//  MULT 8'hFF*8'h02 -> rspValid 5 cycles after accept; result equals the ALU lo
//   register of that product (8'hFE).
//  DIV 8'h10/8'h00 -> rspFlags[3]=1; errCount increments by 1.
//  Opcode 8'hFF -> rspFlags[3]=1; FSM returns to IDLE after handshake.
//  rspReady held 0 for 10 cycles -> rspValid and data stable, reqReady=0,
//   new reqValid ignored; rspReady=1 -> IDLE the next cycle.
//  rst asserted in WR_A -> next cycle IDLE, aluWriteEn=0, rspValid=0; counters zero.

Source files
------------

// File: rtl/alu_issue_sequencer.sv
// Issue sequencer in front of the ALU top: takes one {op,A,B} request, loads the
// instruction reg file (addr 0/1/2), waits for the ALU to settle, returns result+flags.
module alu_issue_sequencer #(
  parameter int                          OPERAND_WIDTH     = 8,
  parameter int                          INST_ADDR_LENGTH  = 2,
  parameter logic [OPERAND_WIDTH-1:0]    OP_MULT_CODE      = 8'h05,
  parameter int                          SETTLE_CYCLES     = 1,
  parameter int                          MULT_EXTRA_CYCLES = 1,
  parameter int                          CNT_WIDTH         = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        reqValid,
  output logic                        reqReady,
  input  logic [OPERAND_WIDTH-1:0]    reqOp,
  input  logic [OPERAND_WIDTH-1:0]    reqA,
  input  logic [OPERAND_WIDTH-1:0]    reqB,
  output logic                        rspValid,
  input  logic                        rspReady,
  output logic [OPERAND_WIDTH-1:0]    rspResult,
  output logic [3:0]                  rspFlags,
  output logic                        aluWriteEn,
  output logic [INST_ADDR_LENGTH-1:0] aluWriteAddress,
  output logic [OPERAND_WIDTH-1:0]    aluInst,
  input  logic [OPERAND_WIDTH-1:0]    aluResult,
  input  logic [3:0]                  aluFlags,
  output logic                        busy,
  output logic [CNT_WIDTH-1:0]        txnCount,
  output logic [CNT_WIDTH-1:0]        errCount
);

  localparam int N_MAX = SETTLE_CYCLES + MULT_EXTRA_CYCLES;
  localparam int WC_W  = (N_MAX < 2) ? 1 : $clog2(N_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_OP, S_WR_A, S_WR_B, S_WAIT, S_RESP
  } state_t;

  state_t                     state_q, state_d;
  logic [OPERAND_WIDTH-1:0]   op_q, a_q, b_q;
  logic [WC_W-1:0]            wcnt_q;
  logic [OPERAND_WIDTH-1:0]   result_q;
  logic [3:0]                 flags_q;
  logic [CNT_WIDTH-1:0]       txn_q, err_q;
  logic                       accept, capture, rsp_hs;

  assign accept  = (state_q == S_IDLE) && reqValid;
  assign capture = (state_q == S_WAIT) && (wcnt_q == WC_W'(1));
  assign rsp_hs  = (state_q == S_RESP) && rspReady;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (reqValid) state_d = S_WR_OP;
      S_WR_OP: state_d = S_WR_A;
      S_WR_A:  state_d = S_WR_B;
      S_WR_B:  state_d = S_WAIT;
      S_WAIT:  if (capture) state_d = S_RESP;
      S_RESP:  if (rspReady) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    reqReady        = (state_q == S_IDLE);
    busy            = (state_q != S_IDLE);
    rspValid        = (state_q == S_RESP);
    aluWriteEn      = 1'b0;
    aluWriteAddress = '0;
    aluInst         = '0;
    case (state_q)
      S_WR_OP: begin aluWriteEn = 1'b1; aluWriteAddress = INST_ADDR_LENGTH'(0); aluInst = op_q; end
      S_WR_A:  begin aluWriteEn = 1'b1; aluWriteAddress = INST_ADDR_LENGTH'(1); aluInst = a_q;  end
      S_WR_B:  begin aluWriteEn = 1'b1; aluWriteAddress = INST_ADDR_LENGTH'(2); aluInst = b_q;  end
      default: ;
    endcase
  end

  // Wait counter is loaded while writing B so WAIT lasts exactly N cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      wcnt_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      txn_q    <= '0;
      err_q    <= '0;
    end else begin
      if (accept) begin
        op_q <= reqOp;
        a_q  <= reqA;
        b_q  <= reqB;
      end
      if (state_q == S_WR_B)
        wcnt_q <= (op_q == OP_MULT_CODE) ? WC_W'(SETTLE_CYCLES + MULT_EXTRA_CYCLES)
                                         : WC_W'(SETTLE_CYCLES);
      else if (state_q == S_WAIT)
        wcnt_q <= wcnt_q - WC_W'(1);
      if (capture) begin
        result_q <= aluResult;
        flags_q  <= aluFlags;
      end
      if (rsp_hs) begin
        txn_q <= txn_q + CNT_WIDTH'(1);
        if (flags_q[3] && (err_q != '1))
          err_q <= err_q + CNT_WIDTH'(1);
      end
    end
  end

  assign rspResult = result_q;
  assign rspFlags  = flags_q;
  assign txnCount  = txn_q;
  assign errCount  = err_q;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer with a small behavioural ALU behind it;
// CNT_WIDTH=2 so counter wrap and saturation are reachable.
module tb_alu_issue_sequencer;

  localparam int W  = 8;
  localparam int AW = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          reqValid, reqReady;
  logic [W-1:0]  reqOp, reqA, reqB;
  logic          rspValid, rspReady;
  logic [W-1:0]  rspResult;
  logic [3:0]    rspFlags;
  logic          aluWriteEn;
  logic [AW-1:0] aluWriteAddress;
  logic [W-1:0]  aluInst;
  logic [W-1:0]  aluResult;
  logic [3:0]    aluFlags;
  logic          busy;
  logic [CW-1:0] txnCount, errCount;

  int errors = 0;
  int checks = 0;
  int exp_txn = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  alu_issue_sequencer #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqOp(reqOp), .reqA(reqA), .reqB(reqB),
    .rspValid(rspValid), .rspReady(rspReady),
    .rspResult(rspResult), .rspFlags(rspFlags),
    .aluWriteEn(aluWriteEn), .aluWriteAddress(aluWriteAddress), .aluInst(aluInst),
    .aluResult(aluResult), .aluFlags(aluFlags),
    .busy(busy), .txnCount(txnCount), .errCount(errCount)
  );

  // Behavioural ALU top: reg file + combinational ops; MULT output is registered
  // one cycle behind the reg file so it needs the extra wait.
  localparam logic [W-1:0] OP_ADD = 8'h01, OP_MULT = 8'h05, OP_DIV = 8'h06;
  logic [W-1:0]  rf0 = '0, rf1 = '0, rf2 = '0;
  logic [15:0]   mult_q = '0;
  logic [8:0]    sum;

  always @(posedge clk) begin
    if (aluWriteEn) begin
      if (aluWriteAddress == 2'd0) rf0 <= aluInst;
      if (aluWriteAddress == 2'd1) rf1 <= aluInst;
      if (aluWriteAddress == 2'd2) rf2 <= aluInst;
    end
    mult_q <= rf1 * rf2;
  end

  always_comb begin
    sum       = {1'b0, rf1} + {1'b0, rf2};
    aluResult = '0;
    aluFlags  = 4'b1000;
    case (rf0)
      OP_ADD: begin
        aluResult = sum[7:0];
        aluFlags  = {1'b0, sum[7:0] == 8'h00, sum[8],
                     (rf1[7] == rf2[7]) && (sum[7] != rf1[7])};
      end
      OP_MULT: begin
        aluResult = mult_q[7:0];
        aluFlags  = {1'b0, mult_q[7:0] == 8'h00, mult_q[15:8] != 8'h00, 1'b0};
      end
      OP_DIV: begin
        if (rf2 != 8'h00) begin
          aluResult = rf1 / rf2;
          aluFlags  = {1'b0, (rf1 / rf2) == 8'h00, 2'b00};
        end
      end
      default: ;
    endcase
  end

  typedef struct { int cyc; logic [AW-1:0] addr; logic [W-1:0] data; } wr_t;
  wr_t wr_q[$];
  int  acc_q[$];
  int  cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (aluWriteEn && !rst) wr_q.push_back('{cyc, aluWriteAddress, aluInst});
    if (reqValid && reqReady && !rst) acc_q.push_back(cyc);
  end

  // Issue one request and return edges from accept until rspValid is seen (-1 on timeout).
  task automatic send_req(input logic [W-1:0] op, a, b, output int lat);
    int g;
    lat = -1;
    @(negedge clk);
    rspReady = 1'b0;
    reqOp = op; reqA = a; reqB = b; reqValid = 1'b1;
    g = 0;
    while (!reqReady && g < 20) begin @(negedge clk); g++; end
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (rspValid) begin lat = k; break; end
    end
  endtask

  task automatic finish_rsp();
    @(negedge clk);
    rspReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rspReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; reqValid = 1'b0; rspReady = 1'b0;
    reqOp = '0; reqA = '0; reqB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL reset_reqReady got %b want 1", reqReady); end
    checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL reset_rspValid got %b want 0", rspValid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({aluWriteEn, aluWriteAddress, aluInst} !== 11'h0) begin errors++;
      $display("FAIL reset_alu_if got we=%b addr=%h inst=%h want 0", aluWriteEn, aluWriteAddress, aluInst); end
    checks++; if ({rspResult, rspFlags} !== 12'h0) begin errors++;
      $display("FAIL reset_rsp got %h/%b want 0/0", rspResult, rspFlags); end
    checks++; if ({txnCount, errCount} !== 4'h0) begin errors++;
      $display("FAIL reset_counters got %0d/%0d want 0/0", txnCount, errCount); end
  endtask

  task automatic test_add();
    int lat, a0;
    logic [W-1:0] exp_data [3];
    exp_data[0] = OP_ADD; exp_data[1] = 8'h30; exp_data[2] = 8'h25;
    wr_q.delete(); acc_q.delete();
    send_req(OP_ADD, 8'h30, 8'h25, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL add_latency got %0d want 4", lat); end
    checks++; if (wr_q.size() != 3 || acc_q.size() != 1) begin errors++;
      $display("FAIL add_write_count got %0d writes want 3", wr_q.size()); end
    else begin
      a0 = acc_q[0];
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_q[i].cyc != a0 + 1 + i || wr_q[i].addr !== AW'(i) || wr_q[i].data !== exp_data[i]) begin
          errors++;
          $display("FAIL add_write%0d got cyc+%0d addr=%0d data=%h want cyc+%0d addr=%0d data=%h",
                   i, wr_q[i].cyc - a0, wr_q[i].addr, wr_q[i].data, 1 + i, i, exp_data[i]);
        end
      end
    end
    checks++; if (rspResult !== 8'h55 || rspFlags !== 4'b0000) begin errors++;
      $display("FAIL add_result got %h/%b want 55/0000", rspResult, rspFlags); end
    checks++; if (reqReady !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL add_resp_state got ready=%b busy=%b want 0/1", reqReady, busy); end
    finish_rsp();
    exp_txn = (exp_txn + 1) % 4;
    checks++; if (rspValid !== 1'b0 || reqReady !== 1'b1 || txnCount !== CW'(exp_txn)) begin errors++;
      $display("FAIL add_handshake got valid=%b ready=%b txn=%0d want 0/1/%0d", rspValid, reqReady, txnCount, exp_txn); end
  endtask

  task automatic test_mult();
    int lat;
    send_req(OP_MULT, 8'hFF, 8'h02, lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL mult_latency got %0d want 5", lat); end
    checks++; if (rspResult !== 8'hFE || rspFlags !== 4'b0010) begin errors++;
      $display("FAIL mult_result got %h/%b want fe/0010", rspResult, rspFlags); end
    finish_rsp();
    exp_txn = (exp_txn + 1) % 4;
    checks++; if (txnCount !== CW'(exp_txn) || errCount !== CW'(exp_err)) begin errors++;
      $display("FAIL mult_counters got %0d/%0d want %0d/%0d", txnCount, errCount, exp_txn, exp_err); end
  endtask

  task automatic test_div_zero();
    int lat;
    send_req(OP_DIV, 8'h10, 8'h00, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL div0_latency got %0d want 4", lat); end
    checks++; if (rspFlags[3] !== 1'b1) begin errors++; $display("FAIL div0_error_flag got %b want 1", rspFlags[3]); end
    finish_rsp();
    exp_txn = (exp_txn + 1) % 4; exp_err = 1;
    checks++; if (errCount !== CW'(exp_err) || txnCount !== CW'(exp_txn)) begin errors++;
      $display("FAIL div0_counters got %0d/%0d want %0d/%0d", txnCount, errCount, exp_txn, exp_err); end
  endtask

  task automatic test_bad_opcode();
    int lat;
    send_req(8'hFF, 8'h12, 8'h34, lat);
    checks++; if (lat != 4 || rspFlags !== 4'b1000) begin errors++;
      $display("FAIL badop_resp got lat=%0d flags=%b want 4/1000", lat, rspFlags); end
    finish_rsp();
    exp_txn = (exp_txn + 1) % 4; exp_err = 2;
    checks++; if (reqReady !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL badop_idle got ready=%b busy=%b want 1/0", reqReady, busy); end
    checks++; if (txnCount !== CW'(exp_txn) || errCount !== CW'(exp_err)) begin errors++;
      $display("FAIL badop_counters_wrap got %0d/%0d want %0d/%0d", txnCount, errCount, exp_txn, exp_err); end
  endtask

  task automatic test_err_saturate();
    int lat;
    for (int n = 0; n < 2; n++) begin
      send_req(8'hEE, 8'h00, 8'h00, lat);
      finish_rsp();
      exp_txn = (exp_txn + 1) % 4;
      exp_err = (exp_err < 3) ? exp_err + 1 : 3;
      checks++; if (txnCount !== CW'(exp_txn) || errCount !== CW'(exp_err)) begin errors++;
        $display("FAIL err_saturate%0d got %0d/%0d want %0d/%0d", n, txnCount, errCount, exp_txn, exp_err); end
    end
  endtask

  task automatic test_stall();
    int lat, nwr;
    send_req(OP_ADD, 8'h7F, 8'h01, lat);
    nwr = wr_q.size();
    reqValid = 1'b1; reqOp = OP_DIV; reqA = 8'hAA; reqB = 8'h00;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rspValid !== 1'b1 || rspResult !== 8'h80 || rspFlags !== 4'b0001 || reqReady !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d got valid=%b res=%h flags=%b ready=%b want 1/80/0001/0",
                 i, rspValid, rspResult, rspFlags, reqReady);
      end
      @(posedge clk);
      @(negedge clk);
    end
    reqValid = 1'b0;
    checks++; if (wr_q.size() != nwr) begin errors++;
      $display("FAIL stall_ignored_req got %0d writes want %0d", wr_q.size(), nwr); end
    rspReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rspReady = 1'b0;
    exp_txn = (exp_txn + 1) % 4;
    checks++; if (reqReady !== 1'b1 || rspValid !== 1'b0 || txnCount !== CW'(exp_txn)) begin errors++;
      $display("FAIL stall_release got ready=%b valid=%b txn=%0d want 1/0/%0d", reqReady, rspValid, txnCount, exp_txn); end
  endtask

  task automatic test_back_to_back();
    int g;
    acc_q.delete();
    @(negedge clk);
    reqOp = OP_ADD; reqA = 8'h01; reqB = 8'h02; reqValid = 1'b1; rspReady = 1'b1;
    g = 0;
    while (acc_q.size() < 2 && g < 30) begin @(negedge clk); g++; end
    reqValid = 1'b0;
    checks++; if (acc_q.size() < 2) begin errors++; $display("FAIL b2b_timeout got %0d accepts want 2", acc_q.size()); end
    else if (acc_q[1] - acc_q[0] != 6) begin errors++;
      $display("FAIL b2b_spacing got %0d want 6", acc_q[1] - acc_q[0]); end
    repeat (8) @(negedge clk);
    rspReady = 1'b0;
    exp_txn = (exp_txn + 2) % 4;
    checks++; if (txnCount !== CW'(exp_txn) || rspResult !== 8'h03 || reqReady !== 1'b1) begin errors++;
      $display("FAIL b2b_done got txn=%0d res=%h ready=%b want %0d/03/1", txnCount, rspResult, reqReady, exp_txn); end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    reqOp = OP_ADD; reqA = 8'h11; reqB = 8'h22; reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (aluWriteEn !== 1'b1 || aluWriteAddress !== 2'd1 || aluInst !== 8'h11) begin errors++;
      $display("FAIL rst_in_wr_a got we=%b addr=%0d inst=%h want 1/1/11", aluWriteEn, aluWriteAddress, aluInst); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (reqReady !== 1'b1 || busy !== 1'b0 || aluWriteEn !== 1'b0 || rspValid !== 1'b0) begin errors++;
      $display("FAIL rst_mid_state got ready=%b busy=%b we=%b valid=%b want 1/0/0/0", reqReady, busy, aluWriteEn, rspValid); end
    checks++; if (txnCount !== 2'd0 || errCount !== 2'd0 || rspResult !== 8'h00) begin errors++;
      $display("FAIL rst_mid_clear got txn=%0d err=%0d res=%h want 0/0/00", txnCount, errCount, rspResult); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || rspValid !== 1'b0) begin errors++;
      $display("FAIL rst_mid_stays_idle got busy=%b valid=%b want 0/0", busy, rspValid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mult();
    test_div_zero();
    test_bad_opcode();
    test_err_saturate();
    test_stall();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
